// File: rtl/div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per cycle, MSB first.
// Result is {remainder, quotient} and is held with ready_o until the requester drops start_i.
module div_seq #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int unsigned WORK_W = 2 * DATA_W + 1;

    typedef enum logic [1:0] {
        DIV_FREE,
        DIV_BY_ZERO,
        DIV_ON,
        DIV_END
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [WORK_W-1:0]   work;
    logic [DATA_W-1:0]   divisor;
    logic                signed_q;
    logic                sign1_q;
    logic                sign2_q;

    logic [DATA_W:0]     diff_c;
    logic [DATA_W-1:0]   mag1_c;
    logic [DATA_W-1:0]   mag2_c;
    logic [DATA_W-1:0]   quot_c;
    logic [DATA_W-1:0]   rem_c;
    logic [DATA_W-1:0]   quot_fix_c;
    logic [DATA_W-1:0]   rem_fix_c;
    logic                cnt_done_c;

    // Operand magnitudes; signed operands with the MSB set are two's-complemented.
    assign mag1_c = (signed_div_i && opdata1_i[DATA_W-1]) ? DATA_W'(-opdata1_i) : opdata1_i;
    assign mag2_c = (signed_div_i && opdata2_i[DATA_W-1]) ? DATA_W'(-opdata2_i) : opdata2_i;

    // Trial subtraction; the extra top bit flags a negative difference.
    assign diff_c = {1'b0, work[2*DATA_W-1:DATA_W]} - {1'b0, divisor};

    assign quot_c     = work[DATA_W-1:0];
    assign rem_c      = work[2*DATA_W:DATA_W+1];
    assign quot_fix_c = (signed_q && (sign1_q ^ sign2_q)) ? DATA_W'(-quot_c) : quot_c;
    assign rem_fix_c  = (signed_q && sign1_q) ? DATA_W'(-rem_c) : rem_c;
    assign cnt_done_c = (cnt == CNT_W'(DATA_W));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= DIV_FREE;
            cnt      <= '0;
            work     <= '0;
            divisor  <= '0;
            signed_q <= 1'b0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                DIV_FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (start_i && !annul_i) begin
                        cnt      <= '0;
                        divisor  <= mag2_c;
                        signed_q <= signed_div_i;
                        sign1_q  <= opdata1_i[DATA_W-1];
                        sign2_q  <= opdata2_i[DATA_W-1];
                        work     <= {DATA_W'(0), mag1_c, 1'b0};
                        state    <= (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
                    end
                end

                DIV_BY_ZERO: begin
                    if (annul_i) begin
                        state <= DIV_FREE;
                    end else begin
                        result_o <= '0;
                        ready_o  <= 1'b1;
                        state    <= DIV_END;
                    end
                end

                DIV_ON: begin
                    // A flush or a withdrawn request abandons the partial result.
                    if (annul_i || !start_i) begin
                        ready_o <= 1'b0;
                        state   <= DIV_FREE;
                    end else if (!cnt_done_c) begin
                        if (diff_c[DATA_W]) begin
                            work <= {work[2*DATA_W-1:0], 1'b0};
                        end else begin
                            work <= {diff_c[DATA_W-1:0], work[DATA_W-1:0], 1'b1};
                        end
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        result_o <= {rem_fix_c, quot_fix_c};
                        ready_o  <= 1'b1;
                        state    <= DIV_END;
                    end
                end

                DIV_END: begin
                    if (!start_i) begin
                        ready_o  <= 1'b0;
                        result_o <= '0;
                        state    <= DIV_FREE;
                    end
                end

                default: begin
                    state <= DIV_FREE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: latency, signed/unsigned results, divide-by-zero, annul and async reset.
module tb_div_seq;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int unsigned passed;
    int unsigned total;

    div_seq #(
        .DATA_W (32),
        .CNT_W  (6)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issue one operation, measure edges to ready_o, then confirm the result holds (annul ignored).
    task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                          input int exp_lat);
        int lat;
        lat          = 0;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (ready_o) begin
                lat = n;
                break;
            end
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, result_o, {er, eq});
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        check({tag, " hold ready"}, 64'(ready_o), 64'd1);
        check({tag, " hold result"}, result_o, {er, eq});
    endtask

    task automatic release_op(input string tag);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " drop ready"}, 64'(ready_o), 64'd0);
        check({tag, " drop result"}, result_o, 64'd0);
    endtask

    initial begin
        passed       = 0;
        total        = 0;
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;

        #2;
        check("reset ready", 64'(ready_o), 64'd0);
        check("reset result", result_o, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        do_div("u100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 34);
        release_op("u100/7");

        do_div("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34);
        release_op("s-7/2");

        do_div("s7/-2", 1'b1, 32'h7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h1, 34);
        release_op("s7/-2");

        do_div("uFFFFFFF9/2", 1'b0, 32'hFFFF_FFF9, 32'h2, 32'h7FFF_FFFC, 32'h1, 34);
        release_op("uFFFFFFF9/2");

        do_div("umax/1", 1'b0, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'h0, 34);
        release_op("umax/1");

        do_div("s overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 34);
        release_op("s overflow");

        do_div("div0", 1'b1, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 2);
        release_op("div0");

        // Request with annul_i high for one edge must not be accepted.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        annul_i      = 1'b1;
        @(posedge clk);
        #1;
        do_div("annulled issue", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 34);
        release_op("annulled issue");

        // Annul at cnt = 10: accept edge plus 10 step edges, then annul for one edge.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        check("annul ready", 64'(ready_o), 64'd0);
        do_div("after annul", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 34);
        release_op("after annul");

        // Asynchronous reset in the middle of an operation.
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        start_i   = 1'b1;
        repeat (6) @(posedge clk);
        #4;
        rst = 1'b1;
        #1;
        check("rst on ready", 64'(ready_o), 64'd0);
        check("rst on result", result_o, 64'd0);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_div("u1000/3", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 34);
        release_op("u1000/3");

        // Asynchronous reset while a finished result is being held.
        do_div("udeadbeef/16", 1'b0, 32'hDEAD_BEEF, 32'h10, 32'h0DEA_DBEE, 32'hF, 34);
        #3;
        rst = 1'b1;
        #1;
        check("rst end ready", 64'(ready_o), 64'd0);
        check("rst end result", result_o, 64'd0);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_div("s-100/7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 34);
        release_op("s-100/7");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle sequencer for 32-bit signed/unsigned integer division (DIV/DIVU) used by the EX stage.
- Takes operands from EX and produces one quotient bit per cycle (restoring algorithm, MSB first).
- Returns {remainder, quotient} with a ready handshake.
- EX holds its stall request asserted until ready_o is seen.

Parameters:
- DATA_W, 32, operand width; quotient and remainder are each DATA_W bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  input  1  core clock; all state changes on the rising edge.
- rst  input  1  asynchronous reset, active-high (`RstEnable` = 1).
- signed_div_i  input  1  1 = signed DIV, 0 = unsigned DIVU; sampled at accept.
- opdata1_i  input  DATA_W  dividend; sampled at accept.
- opdata2_i  input  DATA_W  divisor; sampled at accept.
- start_i  input  1  request; EX holds it high from issue until it has consumed ready_o.
- annul_i  input  1  cancel the operation in flight (pipeline flush/exception).
- result_o  output  2*DATA_W  {remainder[63:32], quotient[31:0]}.
- ready_o  output  1  result_o valid.

Behaviour:
- Reset (asynchronous, any state):
  - state = DivFree, cnt = 0, working register = 0.
  - result_o = 0, ready_o = 0.
- States: DivFree, DivByZero, DivOn, DivEnd. Outputs are registered.
- DivFree:
  - ready_o = 0, result_o = 0.
  - Accept when start_i = 1 and annul_i = 0.
    - If opdata2_i == 0: go to DivByZero.
    - Otherwise go to DivOn, cnt = 0.
    - Latch magnitudes: when signed_div_i = 1 and the operand MSB = 1, take its two's-complement; else use the operand as is.
    - Latch signed_div_i and both operand sign bits.
    - Working register (2*DATA_W+1 bits) = {32'b0, |dividend|, 1'b0}.
  - start_i = 1 with annul_i = 1: not accepted, stay in DivFree.
- DivByZero:
  - Next edge: DivEnd with result_o = 0 and ready_o = 1.
  - If annul_i = 1 instead: go to DivFree.
- DivOn, cnt < 32, each cycle:
  - diff = {1'b0, work[63:32]} - {1'b0, divisor}.
  - If diff is negative: work = {work[63:0], 1'b0}.
  - Else: work = {diff[31:0], work[31:0], 1'b1}.
  - cnt increments by 1.
- DivOn, cnt == 32:
  - Quotient = work[31:0]; remainder = work[64:33].
  - Signed op: negate the quotient if the latched dividend and divisor signs differ.
  - Signed op: negate the remainder if the dividend sign = 1 (remainder takes the dividend's sign).
  - Register the result into result_o, set ready_o = 1, go to DivEnd.
- DivOn exits:
  - annul_i = 1 or start_i = 0 at any DivOn edge: go to DivFree, ready_o stays 0, partial result discarded.
  - annul_i takes priority over the step.
- DivEnd:
  - result_o and ready_o are held while start_i = 1.
  - start_i = 0: go to DivFree; ready_o = 0 and result_o = 0 on that edge.
  - annul_i is ignored in DivEnd.
- Latency:
  - Accept edge E0, 32 step edges E1..E32, ready_o high after E33.
  - Earliest new accept is the edge after start_i drops.
  - Divide-by-zero: ready_o high after E1.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. No trap.
- No back-to-back pipelining: one operation in flight.

Test Plan:
- Unsigned 100 / 7 (signed_div_i = 0, start held) -> ready_o rises after 33 edges past accept; result_o = {32'd2, 32'd14}; held until start_i drops, then 0 the next cycle.
- Signed -7 / 2 (0xFFFFFFF9, 0x2) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / -2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- Unsigned 0xFFFFFFFF / 0x00000001 -> quotient 0xFFFFFFFF, remainder 0. Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
- Divide by zero (any dividend, divisor 0) -> ready_o = 1 after 2 edges, result_o = 0.
- annul_i pulsed at cnt = 10 -> state DivFree, ready_o never asserts. A following 100 / 7 accepted next cycle completes correctly.
- rst asserted asynchronously mid-DivOn (between clock edges) -> result_o = 0, ready_o = 0 immediately. After release, a new operation completes with correct latency.
